// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into one-cycle press/release/click/double_click/long_press pulses.
// Optional macro AUTO_REPEAT_EN adds periodic repeat pulses while a long press stays held.
module button_event_classifier #(
    parameter int unsigned LONG_COUNT   = 50_000_000,
    parameter int unsigned DOUBLE_GAP   = 25_000_000,
    parameter int unsigned REPEAT_COUNT = 10_000_000,
    parameter int unsigned CNT_W        = 26
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_i,
    output logic             press_o,
    output logic             release_o,
    output logic             click_o,
    output logic             double_click_o,
    output logic             long_press_o,
    output logic             repeat_pulse_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] count_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        LONG   = 3'd2,
        GAP    = 3'd3,
        PRESS2 = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    // Plain vector so illegal encodings can exist and be recovered from.
    logic [2:0]       state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             btn_q;
    logic             rise, fall;
    logic             press_q, release_q, click_q, click_d;
    logic             dbl_q, dbl_d, long_q, long_d;

    assign rise = btn_i & ~btn_q;
    assign fall = ~btn_i & btn_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_COUNT - 1);
    logic repeat_q, repeat_d;
`endif

    always_comb begin
        state_d = state_e'(state_q);
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
`ifdef AUTO_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (rise) state_d = PRESS1;
            PRESS1: begin
                if (fall) begin
                    state_d = GAP;
                end else if (count_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_d = IDLE;
                end
`ifdef AUTO_REPEAT_EN
                else if (count_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                end
`endif
            end
            // A rise on the timeout edge is a double click, never a click.
            GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                    dbl_d   = 1'b1;
                end else if (count_q == GAP_LAST) begin
                    state_d = IDLE;
                    click_d = 1'b1;
                end
            end
            PRESS2: if (fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        count_d = count_q;
        if (state_d != state_q) begin
            count_d = '0;
        end else if (state_q == LONG) begin
`ifdef AUTO_REPEAT_EN
            count_d = repeat_d ? '0 : count_q + 1'b1;
`endif
        end else if (count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dbl_q     <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            btn_q     <= btn_i;
            press_q   <= rise;
            release_q <= fall;
            click_q   <= click_d;
            dbl_q     <= dbl_d;
            long_q    <= long_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse_o = repeat_q;
`else
    assign repeat_pulse_o = 1'b0;
`endif

    assign press_o        = press_q;
    assign release_o      = release_q;
    assign click_o        = click_q;
    assign double_click_o = dbl_q;
    assign long_press_o   = long_q;
    assign state_o        = state_q;
    assign count_o        = count_q;

endmodule
